// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped write-back cache: request opcodes and controller states.
package cache_pkg;

    typedef enum logic [1:0] {
        Op_INVALID = 2'd0,
        Op_READ    = 2'd1,
        Op_WRITE   = 2'd2
    } Op_t;

    // Controller states kept as plain constants so older tools see simple vectors.
    typedef logic [1:0] State_t;
    localparam State_t State_IDLE = 2'd0;
    localparam State_t State_WB   = 2'd1;
    localparam State_t State_FILL = 2'd2;

    localparam int ADDR_WIDTH_DEF  = 6;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int INDEX_WIDTH_DEF = 3;

endpackage

// File: rtl/cache_if.sv
// Request-side and memory-side bus bundle for the cache.
interface cache_if
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    Op_t                   req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_vld;
    logic [DATA_WIDTH-1:0] rsp_data;
    Op_t                   mem_req_op;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic                  mem_rsp_vld;
    logic [DATA_WIDTH-1:0] mem_rsp_data;

    // Cache view.
    modport slave (
        input  req_op, req_addr, req_data, mem_rsp_vld, mem_rsp_data,
        output rsp_vld, rsp_data, mem_req_op, mem_req_addr, mem_req_data
    );

    // Requester plus memory-model view.
    modport master (
        output req_op, req_addr, req_data, mem_rsp_vld, mem_rsp_data,
        input  rsp_vld, rsp_data, mem_req_op, mem_req_addr, mem_req_data
    );
endinterface

// File: rtl/cache_array.sv
// Tag/valid/dirty/data storage: combinational indexed read, one write port.
module cache_array #(
    parameter int INDEX_WIDTH = 3,
    parameter int TAG_WIDTH   = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic                   rd_dirty,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_dirty
);
    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_WIDTH-1:0]  tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    // Valid/dirty bits clear on reset; any write installs a valid line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
            dirty_q[wr_index] <= wr_dirty;
        end
    end

    // Tag and data arrays carry no reset; valid gates their meaning.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];
endmodule

// File: rtl/cache.sv
// Direct-mapped write-back write-allocate cache: controller FSM and one-entry pending buffer.
module cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
    input  logic    clk,
    input  logic    rst,
    cache_if.slave  bus
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

    State_t                state_q, state_d;
    // Request currently being serviced by WB/FILL.
    Op_t                   cur_op_q, cur_op_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_WIDTH-1:0] cur_data_q, cur_data_d;
    // One-entry pending buffer.
    logic                  pend_vld_q, pend_vld_d;
    Op_t                   pend_op_q, pend_op_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    // Registered outputs.
    logic                  rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    Op_t                   mem_op_q, mem_op_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

    logic                   req_vld;
    Op_t                    sel_op;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_vld;
    logic [INDEX_WIDTH-1:0] rd_index;
    logic                   rd_valid, rd_dirty, hit;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   wr_en, wr_dirty;
    logic [TAG_WIDTH-1:0]   wr_tag;
    logic [DATA_WIDTH-1:0]  wr_data;

    assign req_vld = (bus.req_op != Op_INVALID);

    // In IDLE a buffered request always goes ahead of the incoming one.
    assign sel_vld  = pend_vld_q | req_vld;
    assign sel_op   = pend_vld_q ? pend_op_q   : bus.req_op;
    assign sel_addr = pend_vld_q ? pend_addr_q : bus.req_addr;
    assign sel_data = pend_vld_q ? pend_data_q : bus.req_data;

    assign rd_index = (state_q == State_IDLE) ? sel_addr[INDEX_WIDTH-1:0]
                                              : cur_addr_q[INDEX_WIDTH-1:0];
    assign hit = rd_valid && (rd_tag == sel_addr[ADDR_WIDTH-1:INDEX_WIDTH]);

    cache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (rd_index),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (rd_index),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data),
        .wr_dirty (wr_dirty)
    );

    // Next-state, array write and output decisions.
    always_comb begin
        state_d     = state_q;
        cur_op_d    = cur_op_q;
        cur_addr_d  = cur_addr_q;
        cur_data_d  = cur_data_q;
        pend_vld_d  = pend_vld_q;
        pend_op_d   = pend_op_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        rsp_vld_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        mem_op_d    = Op_INVALID;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        wr_en       = 1'b0;
        wr_dirty    = 1'b0;
        wr_tag      = cur_addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
        wr_data     = cur_data_q;

        // Park a new request while busy; a full buffer drops it.
        if (state_q != State_IDLE && req_vld && !pend_vld_q) begin
            pend_vld_d  = 1'b1;
            pend_op_d   = bus.req_op;
            pend_addr_d = bus.req_addr;
            pend_data_d = bus.req_data;
        end

        case (state_q)
            State_IDLE: begin
                if (pend_vld_q) begin
                    pend_vld_d  = req_vld;
                    pend_op_d   = bus.req_op;
                    pend_addr_d = bus.req_addr;
                    pend_data_d = bus.req_data;
                end
                if (sel_vld) begin
                    cur_op_d   = sel_op;
                    cur_addr_d = sel_addr;
                    cur_data_d = sel_data;
                    if (hit) begin
                        if (sel_op == Op_READ) begin
                            rsp_vld_d  = 1'b1;
                            rsp_data_d = rd_data;
                        end else begin
                            wr_en    = 1'b1;
                            wr_dirty = 1'b1;
                            wr_tag   = sel_addr[ADDR_WIDTH-1:INDEX_WIDTH];
                            wr_data  = sel_data;
                        end
                    end else if (rd_valid && rd_dirty) begin
                        state_d    = State_WB;
                        mem_op_d   = Op_WRITE;
                        mem_addr_d = {rd_tag, sel_addr[INDEX_WIDTH-1:0]};
                        mem_data_d = rd_data;
                    end else if (sel_op == Op_WRITE) begin
                        wr_en    = 1'b1;
                        wr_dirty = 1'b1;
                        wr_tag   = sel_addr[ADDR_WIDTH-1:INDEX_WIDTH];
                        wr_data  = sel_data;
                    end else begin
                        state_d    = State_FILL;
                        mem_op_d   = Op_READ;
                        mem_addr_d = sel_addr;
                    end
                end
            end
            State_WB: begin
                if (bus.mem_rsp_vld) begin
                    if (cur_op_q == Op_READ) begin
                        state_d    = State_FILL;
                        mem_op_d   = Op_READ;
                        mem_addr_d = cur_addr_q;
                    end else begin
                        state_d  = State_IDLE;
                        wr_en    = 1'b1;
                        wr_dirty = 1'b1;
                    end
                end
            end
            State_FILL: begin
                if (bus.mem_rsp_vld) begin
                    state_d    = State_IDLE;
                    wr_en      = 1'b1;
                    wr_data    = bus.mem_rsp_data;
                    rsp_vld_d  = 1'b1;
                    rsp_data_d = bus.mem_rsp_data;
                end
            end
            default: state_d = State_IDLE;
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= State_IDLE;
            cur_op_q    <= Op_INVALID;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            pend_vld_q  <= 1'b0;
            pend_op_q   <= Op_INVALID;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_data_q  <= '0;
            mem_op_q    <= Op_INVALID;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_op_q    <= cur_op_d;
            cur_addr_q  <= cur_addr_d;
            cur_data_q  <= cur_data_d;
            pend_vld_q  <= pend_vld_d;
            pend_op_q   <= pend_op_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_data_q  <= rsp_data_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    // Flag a request that arrives while busy with the buffer already full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(state_q != State_IDLE && req_vld && pend_vld_q))
            else $error("cache: request dropped, pending buffer full");
        end
    end

    assign bus.rsp_vld      = rsp_vld_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.mem_req_op   = mem_op_q;
    assign bus.mem_req_addr = mem_addr_q;
    assign bus.mem_req_data = mem_data_q;
endmodule

// File: tb/tb_cache.sv
// Scoreboard bench for the cache: stimulus pushes expectations, monitors pop and compare.
module tb_cache;
    import cache_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rsp_exp_t;

    typedef struct {
        Op_t        op;
        logic [5:0] addr;
        logic [7:0] data;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   mem_lat = 2;
    bit   mem_busy = 1'b0;
    bit   inject_stray = 1'b0;
    logic [7:0] mem [64];

    rsp_exp_t exp_rsp[$];
    mem_exp_t exp_mem[$];

    cache_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus ();

    cache #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .INDEX_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Call at a negedge; leaves the request on the bus for exactly one cycle.
    task automatic send(input Op_t op, input logic [5:0] addr, input logic [7:0] data);
        bus.req_op   = op;
        bus.req_addr = addr;
        bus.req_data = data;
        @(negedge clk);
        bus.req_op   = Op_INVALID;
    endtask

    task automatic exp_read(input logic [7:0] data, input int at_cyc);
        rsp_exp_t e;
        e.data = data;
        e.cyc  = at_cyc;
        exp_rsp.push_back(e);
    endtask

    task automatic exp_mreq(input Op_t op, input logic [5:0] addr, input logic [7:0] data);
        mem_exp_t e;
        e.op   = op;
        e.addr = addr;
        e.data = data;
        exp_mem.push_back(e);
    endtask

    // Wait (bounded) for every expectation to be consumed and memory to go idle.
    task automatic drain(input string name);
        int left;
        for (int i = 0; i < 200; i++) begin
            if (exp_rsp.size() == 0 && exp_mem.size() == 0 && !mem_busy) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        left = exp_rsp.size() + exp_mem.size();
        chk(name, left, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rsp_vld"}, int'(bus.rsp_vld), 0);
        chk({tag, "_rsp_data"}, int'(bus.rsp_data), 0);
        chk({tag, "_mem_op"}, int'(bus.mem_req_op), int'(Op_INVALID));
        chk({tag, "_mem_addr"}, int'(bus.mem_req_addr), 0);
        chk({tag, "_mem_data"}, int'(bus.mem_req_data), 0);
    endtask

    // Response monitor.
    initial begin
        rsp_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_vld) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got=0x%0h expected no response", bus.rsp_data);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_data", int'(bus.rsp_data), int'(e.data));
                    if (e.cyc >= 0) chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Memory model: checks each request against the scoreboard, answers after mem_lat cycles.
    initial begin
        mem_exp_t e;
        Op_t        op;
        logic [5:0] addr;
        bit         aborted;
        bus.mem_rsp_vld  = 1'b0;
        bus.mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            bus.mem_rsp_vld = 1'b0;
            if (inject_stray) begin
                inject_stray     = 1'b0;
                bus.mem_rsp_vld  = 1'b1;
                bus.mem_rsp_data = 8'hEE;
            end else if (!rst && bus.mem_req_op != Op_INVALID) begin
                mem_busy = 1'b1;
                op   = bus.mem_req_op;
                addr = bus.mem_req_addr;
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req: op=%0d addr=0x%0h expected none",
                             op, addr);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_op", int'(op), int'(e.op));
                    chk("mem_addr", int'(addr), int'(e.addr));
                    if (e.op == Op_WRITE) chk("mem_wdata", int'(bus.mem_req_data), int'(e.data));
                end
                if (op == Op_WRITE) mem[addr] = bus.mem_req_data;
                aborted = 1'b0;
                for (int i = 1; i < mem_lat; i++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                end
                if (rst) aborted = 1'b1;
                if (!aborted) begin
                    bus.mem_rsp_vld  = 1'b1;
                    bus.mem_rsp_data = (op == Op_READ) ? mem[addr] : 8'h00;
                end
                mem_busy = 1'b0;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int c;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[5] = 8'h00;
        bus.req_op   = Op_INVALID;
        bus.req_addr = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Cold read miss.
        exp_mreq(Op_READ, 6'h05, 8'h00);
        exp_read(8'h00, -1);
        send(Op_READ, 6'h05, 8'h00);
        drain("drain_cold_read");

        // Write hit then read hit with one-cycle latency.
        send(Op_WRITE, 6'h05, 8'hA7);
        c = cyc;
        exp_read(8'hA7, c + 1);
        send(Op_READ, 6'h05, 8'h00);
        drain("drain_hit");

        // Write miss on dirty line: victim written back.
        exp_mreq(Op_WRITE, 6'h05, 8'hA7);
        send(Op_WRITE, 6'h0D, 8'h3C);
        drain("drain_wmiss_dirty");

        // Read miss on dirty line: write-back then fill.
        exp_mreq(Op_WRITE, 6'h0D, 8'h3C);
        exp_mreq(Op_READ, 6'h05, 8'h00);
        exp_read(8'hA7, -1);
        send(Op_READ, 6'h05, 8'h00);
        drain("drain_rmiss_dirty");
        chk("mem_0d_written", int'(mem[6'h0D]), 8'h3C);

        // Request during FILL is buffered and served afterwards.
        mem_lat = 4;
        exp_mreq(Op_READ, 6'h12, 8'h00);
        exp_read(8'h48, -1);
        exp_read(8'hA7, -1);
        send(Op_READ, 6'h12, 8'h00);
        send(Op_READ, 6'h05, 8'h00);
        drain("drain_buffered");

        // Back-to-back hits, each answered the next cycle.
        c = cyc;
        exp_read(8'h48, c + 1);
        exp_read(8'hA7, c + 2);
        send(Op_READ, 6'h12, 8'h00);
        send(Op_READ, 6'h05, 8'h00);
        drain("drain_b2b");

        // Reset in the middle of a fill.
        exp_mreq(Op_READ, 6'h1B, 8'h00);
        send(Op_READ, 6'h1B, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midfill");
        exp_rsp.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        inject_stray = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_no_mem_req", int'(bus.mem_req_op), int'(Op_INVALID));

        // Lines were invalidated: both addresses miss again.
        mem_lat = 2;
        exp_mreq(Op_READ, 6'h1B, 8'h00);
        exp_read(8'h41, -1);
        send(Op_READ, 6'h1B, 8'h00);
        drain("drain_post_reset_1b");
        exp_mreq(Op_READ, 6'h05, 8'h00);
        exp_read(8'hA7, -1);
        send(Op_READ, 6'h05, 8'h00);
        drain("drain_post_reset_05");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cache.md
Name: cache

Overview:
- Direct-mapped, write-back, write-allocate cache that serves byte reads and writes from the MemBus request side.
- Sits between the request master on MemBus and a backing main-memory model behind a second, memory-side port.
- One data word per line, so a miss never needs a partial-line fetch.
- Hides memory latency on hits and serialises victim write-back and fill on misses.

Parameters:
ADDR_WIDTH, 6, byte address width (64-entry address space)
DATA_WIDTH, 8, data word width
INDEX_WIDTH, 3, line index bits (8 lines); tag width = ADDR_WIDTH - INDEX_WIDTH

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
req_op  input  2  pkg::Op_t; non-INVALID for exactly one cycle per request
req_addr  input  ADDR_WIDTH  request address
req_data  input  DATA_WIDTH  write data, valid with Op_WRITE
rsp_vld  output  1  one-cycle pulse: read data valid
rsp_data  output  DATA_WIDTH  read data, meaningful only when rsp_vld=1
mem_req_op  output  2  pkg::Op_t to main memory, one-cycle pulse
mem_req_addr  output  ADDR_WIDTH  memory address
mem_req_data  output  DATA_WIDTH  victim data on Op_WRITE
mem_rsp_vld  input  1  one pulse per memory request: read data or write ack
mem_rsp_data  input  DATA_WIDTH  fill data, valid with mem_rsp_vld on reads

Behaviour:
- Reset (async): state=IDLE, all valid/dirty bits=0, pending buffer empty, rsp_vld=0, rsp_data=0, mem_req_op=Op_INVALID, mem_req_addr=0, mem_req_data=0. Tag/data arrays are not reset.
- Address split: index = addr[INDEX_WIDTH-1:0], tag = addr[ADDR_WIDTH-1:INDEX_WIDTH].
- Hit = valid[index] && tag matches.
- Pending buffer: one entry. A request arriving while state != IDLE is captured here. The controller consumes it on the cycle it returns to IDLE.
- A request arriving while the pending buffer is full is a protocol violation: assertion fires and the request is dropped.
- A request arriving in IDLE while the buffer holds an entry: serve the buffered one first; the new one takes its place.
- State IDLE, read hit (req sampled at edge N): rsp_vld=1 and rsp_data=line data at edge N+1.
- State IDLE, write hit: data written, dirty set at edge N+1. No response.
- Write miss on clean or invalid line: tag and data overwritten, valid=1, dirty=1, no memory traffic.
- Read miss on clean or invalid line: go to FILL; issue mem_req_op=Op_READ with the request address.
- Any miss on a valid dirty line: go to WB; issue mem_req_op=Op_WRITE, mem_req_addr={old tag,index}, mem_req_data=old data.
- WB: wait for mem_rsp_vld.
  - Then a read goes to FILL as above.
  - A write installs the new data (dirty=1) and returns to IDLE.
- FILL: on mem_rsp_vld, install mem_rsp_data (valid=1, dirty=0), then rsp_vld pulses with that data on the next edge, then IDLE.
- Read-miss latency = mem latency + 2 cycles, plus mem latency + 1 if a write-back is needed.
- mem_req_op is a single-cycle pulse. Exactly one memory request is outstanding at a time.
- mem_rsp_vld in IDLE (stray or pre-reset response) is ignored.
- Simultaneous rsp_vld and a new request in the same cycle: both handled, no stall.
- Reset mid-operation: in-flight state abandoned, dirty data lost. Upstream and memory are reset together.

Decomposition:
- Shared package pkg holds:
  - typedef enum logic [1:0] Op_t {Op_INVALID, Op_READ, Op_WRITE}
  - state enum State_t {State_IDLE, State_WB, State_FILL}
- Tag/valid/dirty/data storage is one natural sub-module, cache_array: indexed read, single write port, async clear of valid/dirty.
- The controller FSM and the pending buffer stay in cache.

Test Plan:
- Reset, then read 0x05 with memory[0x05]=0x00 -> one Op_READ to 0x05, rsp_vld once, rsp_data=0x00.
- Write 0x05=0xA7, then read 0x05 -> no memory traffic; rsp_vld at edge N+1, data 0xA7.
- Write 0x05=0xA7, then write 0x0D=0x3C (same index, dirty victim) -> Op_WRITE addr 0x05 data 0xA7; after ack, line holds 0x0D/0x3C dirty.
- Then read 0x05 -> Op_WRITE 0x0D/0x3C, then Op_READ 0x05; rsp_data=0xA7 from memory.
- Issue a second request during FILL with 4-cycle memory latency -> buffered and served after the first rsp_vld; no request lost.
- Assert rst during FILL -> all outputs zero immediately; a late mem_rsp_vld is ignored; subsequent read of the same address misses again.
